// File: rtl/bsr_seg_chain.sv
// Segmented boundary-scan data register with per-segment bypass, shift counter and live chain length.
// Define BSR_PARITY_EN to enable even-parity checking of the shifted stream before update.
module bsr_seg_chain #(
  parameter int NUM_SEG   = 4,
  parameter int SEG_WIDTH = 8,
  parameter int CNT_W     = 16,
  localparam int W        = NUM_SEG * SEG_WIDTH,
  localparam int LEN_W    = $clog2(W + 1)
) (
  input  logic               ICLK,
  input  logic               rst,
  input  logic [W-1:0]       p_data_in,
  output logic [W-1:0]       p_data_out,
  input  logic               s_data_in,
  output logic               s_data_out,
  input  logic               mode,
  input  logic               capture_dr,
  input  logic               shift_dr,
  input  logic               update_dr,
  input  logic [NUM_SEG-1:0] seg_bypass,
  output logic [LEN_W-1:0]   chain_len,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               parity_err
);

  logic [W-1:0]       r_shift;
  logic [W-1:0]       r_upd;
  logic [NUM_SEG-1:0] r_byp_ff;
  logic [NUM_SEG-1:0] r_byp_lat;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [LEN_W-1:0]   r_chain_len;

  logic [NUM_SEG-1:0] w_seg_out;
  logic [NUM_SEG:0]   w_chain;
  logic [W:0]         w_ext;
  logic [W-1:0]       w_shift_nxt;
  logic [NUM_SEG-1:0] w_byp_nxt;
  logic [W-1:0]       w_upd_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               w_upd_ok;

  // Serial output of each segment: its bypass flop when bypassed, else its LSB cell.
  always_comb begin
    w_seg_out = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (r_byp_lat[k]) begin
        w_seg_out[k] = r_byp_ff[k];
      end else begin
        w_seg_out[k] = r_shift[k*SEG_WIDTH];
      end
    end
  end

  // w_chain[k+1] is the serial input feeding segment k.
  assign w_chain = {s_data_in, w_seg_out};
  assign w_ext   = {1'b0, r_shift};

  always_comb begin
    w_shift_nxt = r_shift;
    w_byp_nxt   = r_byp_ff;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (r_byp_lat[k]) begin
        w_byp_nxt[k] = w_chain[k+1];
      end else begin
        for (int b = 0; b < SEG_WIDTH; b++) begin
          if (b == SEG_WIDTH - 1) begin
            w_shift_nxt[k*SEG_WIDTH+b] = w_chain[k+1];
          end else begin
            w_shift_nxt[k*SEG_WIDTH+b] = w_ext[k*SEG_WIDTH+b+1];
          end
        end
      end
    end
  end

  // Bypassed segments keep their previously updated value.
  always_comb begin
    w_upd_nxt = r_upd;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (!r_byp_lat[k]) begin
        w_upd_nxt[k*SEG_WIDTH +: SEG_WIDTH] = r_shift[k*SEG_WIDTH +: SEG_WIDTH];
      end else begin
        w_upd_nxt[k*SEG_WIDTH +: SEG_WIDTH] = r_upd[k*SEG_WIDTH +: SEG_WIDTH];
      end
    end
  end

  always_comb begin
    w_len_nxt = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (seg_bypass[k]) begin
        w_len_nxt = w_len_nxt + LEN_W'(1);
      end else begin
        w_len_nxt = w_len_nxt + LEN_W'(SEG_WIDTH);
      end
    end
  end

  // Capture has priority over shift; update is independent and sees pre-edge state.
  always_ff @(posedge ICLK) begin
    if (rst) begin
      r_shift     <= '0;
      r_upd       <= '0;
      r_byp_ff    <= '0;
      r_byp_lat   <= '0;
      r_bit_cnt   <= '0;
      r_chain_len <= LEN_W'(W);
    end else begin
      if (capture_dr) begin
        r_shift     <= p_data_in;
        r_byp_lat   <= seg_bypass;
        r_byp_ff    <= '0;
        r_bit_cnt   <= '0;
        r_chain_len <= w_len_nxt;
      end else if (shift_dr) begin
        r_shift  <= w_shift_nxt;
        r_byp_ff <= w_byp_nxt;
        if (r_bit_cnt != {CNT_W{1'b1}}) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
      if (update_dr && w_upd_ok) begin
        r_upd <= w_upd_nxt;
      end
    end
  end

`ifdef BSR_PARITY_EN
  logic r_par;
  logic r_parity_err;

  // An odd running parity at update time blocks the update and flags a sticky error.
  always_ff @(posedge ICLK) begin
    if (rst) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (capture_dr) begin
        r_par <= 1'b0;
      end else if (shift_dr) begin
        r_par <= r_par ^ s_data_in;
      end
      if (update_dr && r_par) begin
        r_parity_err <= 1'b1;
      end else if (capture_dr) begin
        r_parity_err <= 1'b0;
      end
    end
  end

  assign w_upd_ok   = ~r_par;
  assign parity_err = r_parity_err;
`else
  assign w_upd_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign p_data_out = mode ? r_upd : p_data_in;
  assign s_data_out = w_seg_out[0];
  assign chain_len  = r_chain_len;
  assign bit_cnt    = r_bit_cnt;

endmodule

// File: doc/bsr_seg_chain.md
Name: bsr_seg_chain

Overview:
- Parametrised boundary-scan data register, organised as NUM_SEG segments of SEG_WIDTH cells each.
- Each segment can be bypassed individually. A bypassed segment is replaced in the chain by a single bypass flop, which shortens the scan path.
- Provides synchronous capture/shift/update, a shift-bit counter and a live chain-length readout for the JTAG controller.
- Sits between the TAP controller's DR enables and the core's parallel pins. Replaces the fixed-width cell-array BSR.

Parameters:
- NUM_SEG, 4, number of segments (≥1)
- SEG_WIDTH, 8, cells per segment (≥1); total width W = NUM_SEG*SEG_WIDTH
- CNT_W, 16, width of shift-bit counter

Ports:
- ICLK  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- p_data_in  input  W  parallel data from core/pins
- p_data_out  output  W  parallel data to core/pins
- s_data_in  input  1  serial TDI-side input
- s_data_out  output  1  serial TDO-side output
- mode  input  1  0 = functional pass-through, 1 = test (drive update register)
- capture_dr  input  1  one-cycle capture enable
- shift_dr  input  1  shift enable, one bit per ICLK while high
- update_dr  input  1  one-cycle update enable
- seg_bypass  input  NUM_SEG  per-segment bypass request, sampled on capture_dr
- chain_len  output  clog2(W+1)  current scan path length in bits
- bit_cnt  output  CNT_W  shift cycles since last capture, saturating
- parity_err  output  1  only with BSR_PARITY_EN; tied 0 otherwise

Behaviour:
- Reset (rst=1 at edge): clear shift_reg[W-1:0], upd_reg[W-1:0], byp_ff[NUM_SEG-1:0], byp_lat[NUM_SEG-1:0] and bit_cnt. After reset, chain_len=W, p_data_out=p_data_in when mode=0 and 0 when mode=1, s_data_out=0. Reset mid-shift aborts with no update.
- p_data_out is combinational: mode ? upd_reg : p_data_in.
- Capture (capture_dr=1):
  - shift_reg <= p_data_in.
  - byp_lat <= seg_bypass.
  - byp_ff <= 0.
  - bit_cnt <= 0.
- Chain order: s_data_in enters the highest non-bypassed element, and data moves toward bit 0. Segment k covers bits [k*SEG_WIDTH +: SEG_WIDTH]. Segment NUM_SEG-1 is nearest s_data_in; segment 0 is nearest s_data_out.
- Shift (shift_dr=1, capture_dr=0):
  - Non-bypassed segment k: its MSB takes the output of segment k+1 (or s_data_in for k=NUM_SEG-1), and the remaining bits shift right by one.
  - Bypassed segment k: byp_ff[k] takes the same input, and its SEG_WIDTH cells hold.
  - bit_cnt increments and saturates at 2^CNT_W-1.
- s_data_out: shift_reg[0] if segment 0 is active, else byp_ff[0]. It is a pure flop output with no combinational path from s_data_in.
- chain_len = sum over k of (byp_lat[k] ? 1 : SEG_WIDTH). It changes only on the cycle after capture.
- Update (update_dr=1): upd_reg segment k <= shift_reg segment k only for non-bypassed segments; bypassed segments hold upd_reg.
- Simultaneous events:
  - capture_dr and shift_dr: capture wins, no shift that cycle.
  - update_dr with shift_dr: update takes pre-edge shift_reg, and the shift proceeds.
  - update_dr with capture_dr: both occur; update uses pre-capture shift_reg and the old byp_lat.
- Enables are level-sampled each edge. Holding capture_dr high re-captures every cycle. Idle (all enables 0): all state holds.

Optional Feature:
- Macro BSR_PARITY_EN.
- When defined, a parity flop par is handled as follows:
  - cleared on capture;
  - XORed with each shifted-in s_data_in;
  - on update_dr, if par=1 (odd), upd_reg is left unchanged and parity_err is set (sticky);
  - parity_err clears on rst or on the next capture.
- The last bit shifted acts as the even-parity bit of the stream.
- When not defined: no par logic, updates are unconditional, parity_err=0.

Test Plan:
- Reset, then mode=1 -> p_data_out=0, chain_len=32, bit_cnt=0, s_data_out=0; mode=0 with p_data_in=0xA5A5_5A5A -> p_data_out=0xA5A5_5A5A.
- Capture p_data_in=0x1234_5678 with seg_bypass=0, then 32 shifts of s_data_in=0 -> s_data_out emits 0,0,0,1,1,1,1,0... (LSB first), bit_cnt=32.
- seg_bypass=4'b0110, capture, then shift 18 bits ending in pattern 0xFF00 on segs 3,0, then update with mode=1 -> chain_len=18; p_data_out[31:24]=0xFF, [7:0]=0x00, [23:8] unchanged from prior upd_reg.
- capture_dr and shift_dr high in the same cycle -> shift_reg equals p_data_in, bit_cnt=0; update_dr with shift_dr -> upd_reg equals pre-shift value.
- rst asserted after 10 of 32 shifts, then update_dr -> upd_reg stays 0, bit_cnt=0.
- BSR_PARITY_EN: shift 33 bits with an odd count of ones, then update -> upd_reg unchanged, parity_err=1; recapture -> parity_err=0; even stream -> upd_reg loaded.
